serial_adder: RTL and testbench

Bit-serial WIDTH-bit adder built around the existing one-bit full adder. It loads two operands, feeds one bit pair per clock (LSB first) into a single `FullAdderStructure` instance, and feeds the registered carry back as the next bit's carry-in. It sits directly downstream of the full adder: it consumes `s` and `cout` every cycle and supplies `x`, `y` and `cin`. It trades WIDTH cycles of latency for one adder cell.

---
 rtl/serial_add_pkg.sv | 23 ++
 rtl/serial_adder_if.sv | 35 +++
 rtl/FullAdderStructure.sv | 19 +
 rtl/serial_adder.sv | 150 +++++++++++++++
 tb/tb_serial_adder.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding, default
// operand width and the bit-counter width helper.
package serial_add_pkg;

    // Default operand/sum width
    localparam int SERIAL_ADD_WIDTH = 8;

    // Bit counter must count 0..WIDTH-1
    function automatic int serial_add_cnt_width(input int width);
        serial_add_cnt_width = (width > 2) ? $clog2(width) : 1;
    endfunction

    // Counter width for the default operand width
    localparam int SERIAL_ADD_CNT_WIDTH = serial_add_cnt_width(SERIAL_ADD_WIDTH);

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } serial_add_state_e;

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result bundle of the bit-serial adder.
// The optional carry-in is present only when SERIAL_ADD_CIN_EN is defined.
interface serial_adder_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADD_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_ADD_CIN_EN
    logic             cin;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_ADD_CIN_EN
    // Requester side: issues operands, observes the result
    modport master (output start, output a, output b, output cin,
                    input busy, input done, input sum, input cout);
    // Adder side
    modport slave  (input start, input a, input b, input cin,
                    output busy, output done, output sum, output cout);
`else
    // Requester side: issues operands, observes the result
    modport master (output start, output a, output b,
                    input busy, input done, input sum, input cout);
    // Adder side
    modport slave  (input start, input a, input b,
                    output busy, output done, output sum, output cout);
`endif

endinterface

// File: rtl/FullAdderStructure.sv
// One-bit full adder cell, built from explicit gate-level equations.
module FullAdderStructure (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic cout,
    output logic s
);
    logic xy_xor_s;
    logic xy_and_s;
    logic c_and_s;

    assign xy_xor_s = x ^ y;
    assign xy_and_s = x & y;
    assign c_and_s  = xy_xor_s & cin;
    assign s        = xy_xor_s ^ cin;
    assign cout     = xy_and_s | c_and_s;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, registered
// carry feedback. Result = a + b (+ cin when SERIAL_ADD_CIN_EN is defined).
// Latency WIDTH cycles from accepted start to the one-cycle done pulse.
module serial_adder
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADD_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int                CNT_W    = serial_add_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    serial_add_state_e state_r;
    serial_add_state_e state_next_s;

    logic [WIDTH-1:0] sa_r;
    logic [WIDTH-1:0] sb_r;
    logic [WIDTH-1:0] sum_r;
    logic [CNT_W-1:0] cnt_r;
    logic             c_r;
    logic             cout_r;

    logic             fa_s_s;
    logic             fa_cout_s;
    logic             accept_s;
    logic             last_bit_s;
    logic             seed_c_s;
    logic             busy_s;
    logic             done_s;

    // A start is honoured in IDLE and on the edge leaving DONE
    assign accept_s   = bus.start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    assign last_bit_s = (state_r == ST_RUN) && (cnt_r == CNT_LAST);

`ifdef SERIAL_ADD_CIN_EN
    assign seed_c_s = bus.cin;
`else
    assign seed_c_s = 1'b0;
`endif

    FullAdderStructure u_fa (sa_r[0], sb_r[0], c_r, fa_cout_s, fa_s_s);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == CNT_LAST) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM output decode from the registered state
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                busy_s = 1'b1;
                done_s = 1'b0;
            end
            ST_DONE: begin
                busy_s = 1'b0;
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Operand shifters, carry, bit counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_r   <= {WIDTH{1'b0}};
            sb_r   <= {WIDTH{1'b0}};
            sum_r  <= {WIDTH{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            c_r    <= 1'b0;
            cout_r <= 1'b0;
        end else if (accept_s) begin
            sa_r   <= bus.a;
            sb_r   <= bus.b;
            sum_r  <= {WIDTH{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            c_r    <= seed_c_s;
            cout_r <= 1'b0;
        end else if (state_r == ST_RUN) begin
            sa_r   <= {1'b0, sa_r[WIDTH-1:1]};
            sb_r   <= {1'b0, sb_r[WIDTH-1:1]};
            sum_r  <= {fa_s_s, sum_r[WIDTH-1:1]};
            cnt_r  <= cnt_r + CNT_ONE;
            c_r    <= fa_cout_s;
            // Final carry must already be visible in the done cycle
            if (last_bit_s) begin
                cout_r <= fa_cout_s;
            end else begin
                cout_r <= cout_r;
            end
        end else begin
            sa_r   <= sa_r;
            sb_r   <= sb_r;
            sum_r  <= sum_r;
            cnt_r  <= cnt_r;
            c_r    <= c_r;
            cout_r <= cout_r;
        end
    end

    assign bus.busy = busy_s;
    assign bus.done = done_s;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8). Expected results come
// from plain integer addition; timing expectations from the cycle rules.
module tb_serial_adder;
    import serial_add_pkg::*;

    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
        int unsigned total;
        total = int'(a) + int'(b);
`ifdef SERIAL_ADD_CIN_EN
        total = total + int'(c);
`endif
        ref_add = total[W:0];
    endfunction

    function automatic logic rand_cin();
`ifdef SERIAL_ADD_CIN_EN
        rand_cin = 1'($urandom_range(1, 0));
`else
        rand_cin = 1'b0;
`endif
    endfunction

    task automatic drive_req(input logic st, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic c);
        bus.start = st;
        bus.a     = a;
        bus.b     = b;
`ifdef SERIAL_ADD_CIN_EN
        bus.cin   = c;
`endif
    endtask

    // One transaction: start accepted at E0, then watch until done (bounded)
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          output logic [W-1:0] s, output logic co, output int busy_n,
                          output int lat, output logic both_hi);
        @(negedge clk);
        drive_req(1'b1, a, b, c);
        @(negedge clk);
        drive_req(1'b0, W'($urandom), W'($urandom), c);
        busy_n = 0; lat = -1; both_hi = 1'b0; s = '0; co = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (bus.busy) busy_n++;
            if (bus.busy && bus.done) both_hi = 1'b1;
            if (bus.done) begin
                lat = k - 1; s = bus.sum; co = bus.cout;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        drive_req(1'b0, '0, '0, 1'b0);
        rst_n = 1'b0;
        #12;
        checks++;
        if ({bus.busy, bus.done, bus.sum, bus.cout} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0}) begin
            errors++;
            $display("FAIL reset_state busy=%0b done=%0b sum=%h cout=%0b expected all 0",
                     bus.busy, bus.done, bus.sum, bus.cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.busy, bus.done, bus.sum, bus.cout} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0}) begin
                errors++;
                $display("FAIL reset_idle cycle=%0d busy=%0b done=%0b sum=%h cout=%0b expected all 0",
                         i, bus.busy, bus.done, bus.sum, bus.cout);
            end
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [4] = '{8'h35, 8'hFF, 8'hFF, 8'hFF};
        logic [W-1:0] vb [4] = '{8'h4A, 8'h01, 8'hFF, 8'hFF};
        logic         vc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] s; logic co; int busy_n; int lat; logic both;
        logic [W:0]   exp;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], vc[i], s, co, busy_n, lat, both);
            exp = ref_add(va[i], vb[i], vc[i]);
            checks++;
            if ({co, s} !== exp) begin
                errors++;
                $display("FAIL directed_sum[%0d] got cout=%0b sum=%h expected cout=%0b sum=%h",
                         i, co, s, exp[W], exp[W-1:0]);
            end
            checks++;
            if (lat != W || busy_n != W || both !== 1'b0) begin
                errors++;
                $display("FAIL directed_timing[%0d] latency=%0d busy_cycles=%0d overlap=%0b expected %0d %0d 0",
                         i, lat, busy_n, both, W, W);
            end
            @(negedge clk);
            checks++;
            if ({bus.done, bus.cout, bus.sum} !== {1'b0, exp}) begin
                errors++;
                $display("FAIL directed_hold[%0d] done=%0b cout=%0b sum=%h expected done=0 cout=%0b sum=%h",
                         i, bus.done, bus.cout, bus.sum, exp[W], exp[W-1:0]);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, s; logic c, co, both; int busy_n, lat;
        logic [W:0]   exp;
        for (int i = 0; i < 20; i++) begin
            a = W'($urandom); b = W'($urandom); c = rand_cin();
            run_op(a, b, c, s, co, busy_n, lat, both);
            exp = ref_add(a, b, c);
            checks++;
            if ({co, s} !== exp || lat != W || both !== 1'b0) begin
                errors++;
                $display("FAIL random[%0d] a=%h b=%h got cout=%0b sum=%h lat=%0d expected cout=%0b sum=%h lat=%0d",
                         i, a, b, co, s, lat, exp[W], exp[W-1:0], W);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a1, b1, a2, b2; logic c;
        int           done_k [$];
        logic [W:0]   got [$];
        logic [W:0]   e1, e2;
        a1 = W'($urandom); b1 = W'($urandom); a2 = W'($urandom); b2 = W'($urandom);
        c  = rand_cin();
        e1 = ref_add(a1, b1, c); e2 = ref_add(a2, b2, c);
        @(negedge clk);
        drive_req(1'b1, a1, b1, c);
        @(negedge clk);
        drive_req(1'b1, a2, b2, c);
        for (int k = 1; k <= 30; k++) begin
            if (bus.done) begin
                done_k.push_back(k);
                got.push_back({bus.cout, bus.sum});
            end
            if (k == 2 * W + 2) bus.start = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (done_k.size() != 2) begin
            errors++;
            $display("FAIL b2b_done_count got %0d expected 2", done_k.size());
        end else begin
            checks++;
            if (done_k[0] != W + 1 || done_k[1] != 2 * W + 2) begin
                errors++;
                $display("FAIL b2b_done_timing got k=%0d,%0d expected k=%0d,%0d",
                         done_k[0], done_k[1], W + 1, 2 * W + 2);
            end
            checks++;
            if (got[0] !== e1 || got[1] !== e2) begin
                errors++;
                $display("FAIL b2b_results got %h,%h expected %h,%h", got[0], got[1], e1, e2);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] a1, b1; logic c; int n_done; int k_done;
        logic [W:0]   got, e1;
        a1 = W'($urandom); b1 = W'($urandom); c = rand_cin();
        e1 = ref_add(a1, b1, c);
        n_done = 0; k_done = -1; got = '0;
        @(negedge clk);
        drive_req(1'b1, a1, b1, c);
        @(negedge clk);
        drive_req(1'b0, a1, b1, c);
        for (int k = 1; k <= 25; k++) begin
            if (bus.done) begin
                n_done++;
                if (k_done < 0) begin k_done = k; got = {bus.cout, bus.sum}; end
            end
            if (k == 3) drive_req(1'b1, ~a1, b1 ^ 8'h5A, ~c);
            if (k == 4) drive_req(1'b0, '0, '0, 1'b0);
            @(negedge clk);
        end
        checks++;
        if (n_done != 1 || k_done != W + 1 || got !== e1) begin
            errors++;
            $display("FAIL ignore_start dones=%0d k=%0d result=%h expected 1 %0d %h",
                     n_done, k_done, got, W + 1, e1);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] s; logic co, both; int busy_n, lat, n_done;
        @(negedge clk);
        drive_req(1'b1, 8'hFF, 8'hFF, 1'b0);
        @(negedge clk);
        drive_req(1'b0, 8'hFF, 8'hFF, 1'b0);
        for (int k = 1; k < 5; k++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.sum, bus.cout} !== {1'b0, 1'b0, {W{1'b0}}, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_clear busy=%0b done=%0b sum=%h cout=%0b expected all 0",
                     bus.busy, bus.done, bus.sum, bus.cout);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_done = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.done || bus.busy) n_done++;
            @(negedge clk);
        end
        checks++;
        if (n_done != 0) begin
            errors++;
            $display("FAIL reset_mid_no_done activity_cycles=%0d expected 0", n_done);
        end
        run_op(8'h10, 8'h20, 1'b0, s, co, busy_n, lat, both);
        checks++;
        if ({co, s} !== 9'h030 || lat != W) begin
            errors++;
            $display("FAIL reset_mid_restart got cout=%0b sum=%h lat=%0d expected cout=0 sum=30 lat=%0d",
                     co, s, lat, W);
        end
    endtask

    initial begin
        drive_req(1'b0, '0, '0, 1'b0);
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
